// File: rtl/btn_debounce.sv
// Debounces the active-low USER_BTN pad into a clean level plus press/release/long-press strobes.
// Press/release latency DEBOUNCE_CYCLES+2 from first pad sample; no backpressure, strobes are one cycle.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int HOLD_CYCLES     = 12000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic USER_BTN,
    output logic PRESSED,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic HOLD_PULSE
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             press_evt_q;
    logic             release_evt_q;
    logic             pressed_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             hold_pulse_q;
    logic             btn_s;

    assign btn_s = sync_q[1];

    always_comb begin
        db_cnt_d   = db_cnt_q + CNT_ONE;
        hold_cnt_d = hold_cnt_q + CNT_ONE;
    end

    // Accepted changes are flagged in *_evt_q and published one cycle later,
    // so the strobes and the level land together on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q          <= 2'b11;
            state_q         <= IDLE;
            db_cnt_q        <= '0;
            hold_cnt_q      <= '0;
            press_evt_q     <= 1'b0;
            release_evt_q   <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            hold_pulse_q    <= 1'b0;
        end else begin
            sync_q          <= {sync_q[0], USER_BTN};
            press_evt_q     <= 1'b0;
            release_evt_q   <= 1'b0;
            press_pulse_q   <= press_evt_q;
            release_pulse_q <= release_evt_q;
            hold_pulse_q    <= 1'b0;
            if (press_evt_q) begin
                pressed_q <= 1'b1;
            end
            if (release_evt_q) begin
                pressed_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!btn_s) begin
                        state_q  <= PRESS_DB;
                        db_cnt_q <= CNT_ONE;
                    end
                end
                PRESS_DB: begin
                    if (btn_s) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= HELD;
                        db_cnt_q    <= '0;
                        hold_cnt_q  <= '0;
                        press_evt_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                HELD: begin
                    // Hold timing starts on the cycle the press is published.
                    if (!press_evt_q && hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_d;
                        if (hold_cnt_d == HOLD_MAX) begin
                            hold_pulse_q <= 1'b1;
                        end
                    end
                    if (btn_s) begin
                        state_q  <= RELEASE_DB;
                        db_cnt_q <= CNT_ONE;
                    end
                end
                RELEASE_DB: begin
                    if (!btn_s) begin
                        state_q  <= HELD;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q       <= IDLE;
                        db_cnt_q      <= '0;
                        release_evt_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    db_cnt_q <= '0;
                end
            endcase
        end
    end

    assign PRESSED       = pressed_q;
    assign PRESS_PULSE   = press_pulse_q;
    assign RELEASE_PULSE = release_pulse_q;
    assign HOLD_PULSE    = hold_pulse_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int HC = 20;

    // Event word: {PRESS_PULSE, RELEASE_PULSE, HOLD_PULSE, PRESSED}
    localparam logic [3:0] W_PRESS = 4'b1001;
    localparam logic [3:0] W_HOLD  = 4'b0011;
    localparam logic [3:0] W_REL   = 4'b0100;
    localparam logic [3:0] W_DROP  = 4'b0000;

    typedef struct {
        int         cyc;
        logic [3:0] word;
    } exp_t;

    logic CLK      = 1'b0;
    logic RST_N    = 1'b0;
    logic USER_BTN = 1'b1;
    logic PRESSED;
    logic PRESS_PULSE;
    logic RELEASE_PULSE;
    logic HOLD_PULSE;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   n_vec        = 0;
    int   n_err        = 0;
    logic rst_seen     = 1'b0;
    logic mon_en       = 1'b0;
    logic prev_pressed = 1'b0;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .USER_BTN     (USER_BTN),
        .PRESSED      (PRESSED),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .HOLD_PULSE   (HOLD_PULSE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= !RST_N;
        mon_en   <= 1'b1;
    end

    // Monitor: outputs sampled on the falling edge after posedge number cyc.
    always @(negedge CLK) begin
        logic [3:0] word;
        exp_t       e;
        if (mon_en) begin
            word = {PRESS_PULSE, RELEASE_PULSE, HOLD_PULSE, PRESSED};
            if (rst_seen) begin
                n_vec++;
                if (word !== 4'b0000) begin
                    n_err++;
                    $display("FAIL reset_state cyc=%0d got=%b want=0000", cyc, word);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_event cyc=%0d got=none want=%b", e.cyc, e.word);
            end
            if (PRESS_PULSE || RELEASE_PULSE || HOLD_PULSE || (PRESSED != prev_pressed)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, word);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.word !== word) begin
                        n_err++;
                        $display("FAIL event cyc=%0d got=%b want cyc=%0d word=%b",
                                 cyc, word, e.cyc, e.word);
                    end
                end
            end
            prev_pressed = PRESSED;
        end
    end

    // Each iteration sets inputs on a falling edge; the next posedge samples them.
    task automatic apply(input logic btn, input logic rst, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            USER_BTN = btn;
            RST_N    = rst;
        end
    endtask

    function automatic void expect_at(input int c, input logic [3:0] w);
        exp_t e;
        e.cyc  = c;
        e.word = w;
        exp_q.push_back(e);
    endfunction

    initial begin
        int n0;
        int m0;
        int r0;

        // 1: reset with the button released, then idle.
        apply(1'b1, 1'b0, 10);
        apply(1'b1, 1'b1, 5);

        // Called right after a falling edge, so the next applied value is
        // first sampled at posedge cyc+2.

        // 2: clean press held 30 cycles -> press at +6, hold at +26; then release.
        n0 = cyc + 2;
        expect_at(n0 + 6, W_PRESS);
        expect_at(n0 + 26, W_HOLD);
        apply(1'b0, 1'b1, 30);
        m0 = cyc + 2;
        expect_at(m0 + 6, W_REL);
        apply(1'b1, 1'b1, 12);

        // 3: bounce train 3 low / 1 high / 3 low -> nothing accepted.
        apply(1'b0, 1'b1, 3);
        apply(1'b1, 1'b1, 1);
        apply(1'b0, 1'b1, 3);
        apply(1'b1, 1'b1, 10);

        // 4: press, short hold, release with a 2-cycle low glitch.
        // Final stable high starts at n0+18 -> release at n0+24; hold never reached.
        n0 = cyc + 2;
        expect_at(n0 + 6, W_PRESS);
        expect_at(n0 + 24, W_REL);
        apply(1'b0, 1'b1, 14);
        apply(1'b1, 1'b1, 2);
        apply(1'b0, 1'b1, 2);
        apply(1'b1, 1'b1, 12);

        // 5: long press of 60 cycles -> exactly one hold strobe.
        n0 = cyc + 2;
        expect_at(n0 + 6, W_PRESS);
        expect_at(n0 + 26, W_HOLD);
        apply(1'b0, 1'b1, 60);
        m0 = cyc + 2;
        expect_at(m0 + 6, W_REL);
        apply(1'b1, 1'b1, 10);

        // 6: one-cycle reset while held, button kept low -> level drops at the
        // reset edge, press re-fires 6 cycles after the first post-reset edge.
        n0 = cyc + 2;
        expect_at(n0 + 6, W_PRESS);
        apply(1'b0, 1'b1, 10);
        r0 = cyc + 2;
        expect_at(r0, W_DROP);
        expect_at(r0 + 7, W_PRESS);
        apply(1'b0, 1'b0, 1);
        apply(1'b0, 1'b1, 12);
        m0 = cyc + 2;
        expect_at(m0 + 6, W_REL);
        apply(1'b1, 1'b1, 12);

        apply(1'b1, 1'b1, 5);
        @(negedge CLK);
        #1;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event cyc=%0d got=none want=%b", e.cyc, e.word);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
